cache_refill_unit: RTL and testbench
====================================

CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, byte/word address width; DATA_W, default 8, word width; INDEX_W, default 4, set-index bits; OFFSET_W, fixed 2, word offset (4 words/line); TAG_W = ADDR_W-INDEX_W-OFFSET_W (10).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ctrl_state  in  2  cache controller state; 2'b11 = fetch.
REQ-005 miss_addr  in  ADDR_W  address of the missing access.
REQ-006 lru_way  in  1  victim way for the indexed set.
REQ-007 mem_req  out  1  memory read request.
REQ-008 mem_addr  out  ADDR_W  word address being requested.
REQ-009 mem_ack  in  1  memory returns one word; mem_rdata valid same cycle.
REQ-010 mem_rdata  in  DATA_W  returned word.
REQ-011 wr_en  out  1  data-array write strobe.
REQ-012 wr_way / wr_index / wr_offset / wr_data  out  1 / INDEX_W / 2 / DATA_W  data-array write target and data.
REQ-013 tag_we  out  1  tag-array write strobe; writes tag_out and sets valid for wr_way/wr_index.
REQ-014 tag_out  out  TAG_W  tag being installed.
REQ-015 busy  out  1  refill in progress; upstream hit logic SHALL force hit=0 while busy=1.
REQ-016 refill_done  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, REQ, TAG, DONE.
REQ-018 IDLE: on a clock edge with ctrl_state==2'b11, latch tag=miss_addr[ADDR_W-1:6], index=miss_addr[5:2], way=lru_way; beat counter cleared to 0; go REQ.
REQ-019 ctrl_state==2'b11 seen in any state other than IDLE SHALL be ignored (no re-latch, no restart).
REQ-020 REQ: mem_req=1; mem_addr={latched tag, latched index, beat}; burst is line-aligned, starting at offset 0 regardless of miss offset.
REQ-021 mem_req SHALL stay high and mem_addr stable until mem_ack; no timeout.
REQ-022 In REQ with mem_ack=1 (combinational, same cycle): wr_en=1, wr_way=latched way, wr_index=latched index, wr_offset=beat, wr_data=mem_rdata.
REQ-023 Edge with mem_ack=1 in REQ: beat increments; if beat was 3, go TAG (mem_req drops next cycle).
REQ-024 mem_ack outside REQ SHALL be ignored (no write).
REQ-025 TAG: one cycle, tag_we=1, tag_out=latched tag, wr_way/wr_index=latched values; go DONE.
REQ-026 DONE: one cycle, refill_done=1; go IDLE.
REQ-027 busy=1 in REQ, TAG and DONE; 0 in IDLE.
REQ-028 Minimum refill latency (ack every cycle): trigger edge -> 4 REQ cycles -> TAG -> DONE; busy high 6 cycles.
REQ-029 Valid/tag written only after all four words; a partial line SHALL never become valid.
REQ-030 wr_en, tag_we, refill_done mutually exclusive in any cycle.
REQ-031 When not asserted, wr_* and tag_out SHALL be 0 (mem_addr 0 in IDLE/TAG/DONE).

Reset
REQ-032 reset=0 SHALL immediately (no clock) force IDLE, beat=0, latched fields 0, all outputs 0.
REQ-033 Reset mid-refill SHALL abandon it: no tag_we, no refill_done; next refill starts at beat 0.
REQ-034 After reset release, first trigger edge behaves per REQ-018.

Verification
REQ-035 Trigger miss_addr=16'hABCD, lru_way=1, ack every cycle -> mem_addr 16'hABCC,ABCD,ABCE,ABCF; wr_index=4'h3, wr_way=1, offsets 0..3; tag_we with tag_out=10'h2AF; refill_done 6th cycle after trigger edge.
REQ-036 Same trigger, mem_ack only every 3rd cycle -> mem_req/mem_addr held between acks; exactly 4 wr_en pulses; one tag_we, one refill_done.
REQ-037 ctrl_state held 2'b11 throughout a refill and miss_addr changed mid-refill -> single refill to the originally latched address; new refill only on trigger seen in IDLE.
REQ-038 reset=0 asserted after 2nd ack -> all outputs 0 asynchronously; no tag_we/refill_done; subsequent trigger starts at offset 0.
REQ-039 mem_ack pulsed while IDLE -> no wr_en, busy stays 0.
REQ-040 Back-to-back: trigger asserted in the cycle after refill_done -> second refill starts with no lost cycle, correct new tag/index/way.

Source files
------------

// File: rtl/cache_refill_unit.sv
// Line refill engine: on a fetch request it bursts the four words of the missing
// line from memory into the data array, then installs the tag and pulses done.
module cache_refill_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          ctrl_state,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic                lru_way,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wr_en,
    output logic                wr_way,
    output logic [INDEX_W-1:0]  wr_index,
    output logic [OFFSET_W-1:0] wr_offset,
    output logic [DATA_W-1:0]   wr_data,
    output logic                tag_we,
    output logic [TAG_W-1:0]    tag_out,
    output logic                busy,
    output logic                refill_done,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TAG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_FETCH = 2'b11;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TAG_W-1:0]      r_tag;
    logic [INDEX_W-1:0]    r_index;
    logic                  r_way;
    logic [OFFSET_W-1:0]   r_beat;
    logic                  w_trigger;
    logic                  w_beat_ack;

    // Memory handshake: mem_req is held with a stable mem_addr until the cycle
    // mem_ack is high; that cycle transfers one word (mem_rdata) and the next
    // beat's address appears after the clock edge. There is no timeout.
    assign w_trigger  = (r_state == IDLE) && (ctrl_state == CTRL_FETCH);
    assign w_beat_ack = (r_state == REQ) && mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag   <= '0;
            r_index <= '0;
            r_way   <= 1'b0;
            r_beat  <= '0;
        end else if (w_trigger) begin
            r_tag   <= miss_addr[ADDR_W-1:INDEX_W+OFFSET_W];
            r_index <= miss_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
            r_way   <= lru_way;
            r_beat  <= '0;
        end else if (w_beat_ack) begin
            r_beat  <= r_beat + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_addr    = '0;
        wr_en       = 1'b0;
        wr_way      = 1'b0;
        wr_index    = '0;
        wr_offset   = '0;
        wr_data     = '0;
        tag_we      = 1'b0;
        tag_out     = '0;
        refill_done = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_index, r_beat};
                if (mem_ack) begin
                    wr_en     = 1'b1;
                    wr_way    = r_way;
                    wr_index  = r_index;
                    wr_offset = r_beat;
                    wr_data   = mem_rdata;
                    if (r_beat == {OFFSET_W{1'b1}}) begin
                        w_state_nxt = TAG;
                    end
                end
            end
            TAG: begin
                // Valid/tag only go in once the whole line has been written.
                tag_we      = 1'b1;
                tag_out     = r_tag;
                wr_way      = r_way;
                wr_index    = r_index;
                w_state_nxt = DONE;
            end
            DONE: begin
                refill_done = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: directed scenarios plus random
// refills compared cycle by cycle against an address-arithmetic reference model.
module tb_cache_refill_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ctrl_state;
  logic [15:0] miss_addr;
  logic        lru_way;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        wr_en;
  logic        wr_way;
  logic [3:0]  wr_index;
  logic [1:0]  wr_offset;
  logic [7:0]  wr_data;
  logic        tag_we;
  logic [9:0]  tag_out;
  logic        busy;
  logic        refill_done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errs   = 0;

  logic [63:0] obs;
  logic [63:0] all_zero;

  cache_refill_unit dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_state  (ctrl_state),
    .miss_addr   (miss_addr),
    .lru_way     (lru_way),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wr_en       (wr_en),
    .wr_way      (wr_way),
    .wr_index    (wr_index),
    .wr_offset   (wr_offset),
    .wr_data     (wr_data),
    .tag_we      (tag_we),
    .tag_out     (tag_out),
    .busy        (busy),
    .refill_done (refill_done),
    .dbg_state   (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  assign obs = {18'b0, mem_req, mem_addr, wr_en, wr_way, wr_index, wr_offset,
                wr_data, tag_we, tag_out, busy, refill_done};
  assign all_zero = '0;

  function automatic logic [63:0] pk(input logic rq, input logic [15:0] ad,
                                     input logic we, input logic wy,
                                     input logic [3:0] ix, input logic [1:0] of,
                                     input logic [7:0] dt, input logic tw,
                                     input logic [9:0] tg, input logic bz,
                                     input logic dn);
    return {18'b0, rq, ad, we, wy, ix, of, dt, tw, tg, bz, dn};
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", name, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise(input bit hold, input bit chg);
    ctrl_state = hold ? 2'b11 : 2'($urandom_range(0, 3));
    if (chg) begin
      miss_addr = 16'($urandom);
      lru_way   = 1'($urandom);
    end
  endtask

  // One refill; the reference model is line-base arithmetic on the miss address.
  task automatic do_refill(input logic [15:0] a, input logic w, input int min_gap,
                           input int max_gap, input bit hold, input bit chg,
                           input bit abort2, input bit settle);
    logic [15:0] base;
    logic [3:0]  idx;
    logic [9:0]  tg;
    logic [7:0]  d;
    int          gap;
    base = a & 16'hFFFC;
    idx  = a[5:2];
    tg   = a[15:6];
    ctrl_state = 2'b11;
    miss_addr  = a;
    lru_way    = w;
    mem_ack    = 1'b0;
    mem_rdata  = 8'($urandom);
    #1 check("trigger_idle", obs, all_zero);
    tick;
    for (int k = 0; k < 4; k++) begin
      gap = $urandom_range(min_gap, max_gap);
      for (int g = 0; g < gap; g++) begin
        drive_noise(hold, chg);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        #1 check("req_wait", obs, pk(1, base + 16'(k), 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tick;
      end
      drive_noise(hold, chg);
      mem_ack   = 1'b1;
      d         = 8'($urandom);
      mem_rdata = d;
      #1 check("req_ack", obs, pk(1, base + 16'(k), 1, w, idx, 2'(k), d, 0, 0, 1, 0));
      tick;
      if (abort2 && k == 1) begin
        mem_ack = 1'b0;
        reset   = 1'b0;
        #1 check("abort_async", obs, all_zero);
        tick;
        check("abort_hold", obs, all_zero);
        ctrl_state = 2'b00;
        reset      = 1'b1;
        #1 check("abort_release", obs, all_zero);
        tick;
        return;
      end
    end
    drive_noise(hold, chg);
    mem_ack   = 1'b1;
    mem_rdata = 8'($urandom);
    #1 check("tag_cycle", obs, pk(0, 0, 0, w, idx, 0, 0, 1, tg, 1, 0));
    tick;
    drive_noise(hold, chg);
    mem_ack = 1'($urandom);
    #1 check("done_cycle", obs, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tick;
    if (settle) begin
      ctrl_state = 2'b00;
      mem_ack    = 1'b0;
      #1 check("idle_after", obs, all_zero);
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    ctrl_state = 2'b00;
    miss_addr  = '0;
    lru_way    = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    #2 check("reset_state", obs, all_zero);
    tick;
    tick;
    reset = 1'b1;
    #1 check("post_reset_idle", obs, all_zero);
    tick;

    // minimum latency refill of 0xABCD into way 1
    do_refill(16'hABCD, 1'b1, 0, 0, 0, 0, 0, 1);
    // acks every third cycle
    do_refill(16'hABCD, 1'b1, 2, 2, 0, 0, 0, 1);
    // trigger held and address churned during the refill
    do_refill(16'($urandom), 1'($urandom), 0, 2, 1, 1, 0, 1);
    // reset after second ack, then a clean refill from offset 0
    do_refill(16'($urandom), 1'($urandom), 0, 1, 0, 0, 1, 1);
    do_refill(16'($urandom), 1'($urandom), 0, 1, 0, 0, 0, 1);

    // acks while idle must not write
    for (int i = 0; i < 5; i++) begin
      ctrl_state = 2'($urandom_range(0, 2));
      mem_ack    = 1'b1;
      mem_rdata  = 8'($urandom);
      #1 check("idle_ack", obs, all_zero);
      tick;
    end
    mem_ack = 1'b0;

    // back-to-back refills
    do_refill(16'h1234, 1'b0, 0, 0, 0, 0, 0, 0);
    do_refill(16'hFE73, 1'b1, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      do_refill(16'($urandom), 1'($urandom), 0, 3, 1'($urandom), 1'($urandom),
                0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
